// File: rtl/rl_pkg.sv
// Shared reversible-logic definitions: the Fredkin controlled-swap primitive,
// lane identifiers and the per-lane buffer depth.
package rl_pkg;

  localparam int FIFO_DEPTH = 2;

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_e;

  // Controlled swap: P passes c through; Q and R swap a and b when c is 1.
  function automatic logic [2:0] fredkin(input logic c, input logic a, input logic b);
    return {c, (c ? b : a), (c ? a : b)};
  endfunction

endpackage

// File: rtl/fredkin_gate_vec.sv
// W parallel Fredkin cells sharing one control line; purely combinational.
module fredkin_gate_vec
  import rl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         c,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         p,
  output logic [W-1:0] q,
  output logic [W-1:0] r
);

  logic [W-1:0] p_bits;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    p_bits = '0;
    q      = '0;
    r      = '0;
    for (int i = 0; i < W; i++) begin
      {p_bits[i], q[i], r[i]} = fredkin(c, a[i], b[i]);
    end
  end

  // Every cell carries the same control through, so the AND is just c.
  assign p = &p_bits;

endmodule

// File: rtl/fredkin_demux12_buf.sv
// Registered 1:2 Fredkin demultiplexer with a 2-entry FIFO per lane,
// a sticky conservation checker and per-lane transfer counters.
module fredkin_demux12_buf
  import rl_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sel,
  input  logic [W-1:0]  in_data,
  input  logic          fault_inj,
  output logic          out0_valid,
  input  logic          out0_ready,
  output logic [W-1:0]  out0_data,
  output logic          out1_valid,
  input  logic          out1_ready,
  output logic [W-1:0]  out1_data,
  output logic          garbage_sel,
  output logic          cons_err,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1
);

  logic         gate_p;
  logic [W-1:0] gate_q;
  logic [W-1:0] gate_r;
  logic [W-1:0] q_chk;
  logic [W-1:0] wr_data;
  logic         mismatch;
  logic         push;

  logic [W-1:0] mem    [2][FIFO_DEPTH];
  logic [1:0]   occ    [2];
  logic         wr_ptr [2];
  logic         rd_ptr [2];
  logic         full   [2];
  logic         pop    [2];
  logic         lane_push [2];
  logic         out_ready [2];

  lane_e sel_lane;

  fredkin_gate_vec #(.W(W)) u_gate (
    .c (in_sel),
    .a (in_data),
    .b ('0),
    .p (gate_p),
    .q (gate_q),
    .r (gate_r)
  );

  assign sel_lane     = lane_e'(in_sel);
  assign q_chk        = gate_q ^ {{(W-1){1'b0}}, fault_inj};
  assign wr_data      = (sel_lane == LANE1) ? gate_r : q_chk;
  assign out_ready[0] = out0_ready;
  assign out_ready[1] = out1_ready;

  always_comb begin
    for (int l = 0; l < 2; l++) begin
      full[l] = (occ[l] == 2'(FIFO_DEPTH));
      pop[l]  = (occ[l] != 2'd0) & out_ready[l];
    end
  end

  // A pop in the same cycle does not free the slot: no pass-through when full.
  assign in_ready     = ~full[sel_lane];
  assign push         = in_valid & in_ready;
  assign lane_push[0] = push & (sel_lane == LANE0);
  assign lane_push[1] = push & (sel_lane == LANE1);

  // Ones must be conserved cell by cell: {P,Q,R} against {c,a,b=0}.
  always_comb begin
    mismatch = 1'b0;
    for (int i = 0; i < W; i++) begin
      if ($countones({gate_p, q_chk[i], gate_r[i]}) != $countones({in_sel, in_data[i], 1'b0}))
        mismatch = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < 2; l++) begin
        occ[l]    <= 2'd0;
        wr_ptr[l] <= 1'b0;
        rd_ptr[l] <= 1'b0;
        // NOTE: buffer storage is reset because the head word is visible on out*_data straight out of reset.
        for (int e = 0; e < FIFO_DEPTH; e++) mem[l][e] <= '0;
      end
    end else begin
      for (int l = 0; l < 2; l++) begin
        if (lane_push[l]) begin
          mem[l][wr_ptr[l]] <= wr_data;
          wr_ptr[l]         <= ~wr_ptr[l];
        end
        if (pop[l]) rd_ptr[l] <= ~rd_ptr[l];
        if (lane_push[l] && !pop[l])      occ[l] <= occ[l] + 2'd1;
        else if (!lane_push[l] && pop[l]) occ[l] <= occ[l] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      garbage_sel <= 1'b0;
      cons_err    <= 1'b0;
      cnt0        <= '0;
      cnt1        <= '0;
    end else if (push) begin
      garbage_sel <= gate_p;
      if (mismatch) cons_err <= 1'b1;
      if (sel_lane == LANE0) cnt0 <= cnt0 + CW'(1);
      else                   cnt1 <= cnt1 + CW'(1);
    end
  end

  assign out0_valid = (occ[0] != 2'd0);
  assign out1_valid = (occ[1] != 2'd0);
  assign out0_data  = mem[0][rd_ptr[0]];
  assign out1_data  = mem[1][rd_ptr[1]];

endmodule

// File: tb/tb_fredkin_demux12_buf.sv
// Directed bench for fredkin_demux12_buf: routing, back-pressure, push/pop,
// fault detection, counter wrap and asynchronous reset.
module tb_fredkin_demux12_buf;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_sel, fault_inj;
  logic [W-1:0]  in_data;
  logic          out0_valid, out0_ready, out1_valid, out1_ready;
  logic [W-1:0]  out0_data, out1_data;
  logic          garbage_sel, cons_err;
  logic [CW-1:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  fredkin_demux12_buf #(.W(W), .CW(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sel      (in_sel),
    .in_data     (in_data),
    .fault_inj   (fault_inj),
    .out0_valid  (out0_valid),
    .out0_ready  (out0_ready),
    .out0_data   (out0_data),
    .out1_valid  (out1_valid),
    .out1_ready  (out1_ready),
    .out1_data   (out1_data),
    .garbage_sel (garbage_sel),
    .cons_err    (cons_err),
    .cnt0        (cnt0),
    .cnt1        (cnt1)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [W-1:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    in_valid = 0; in_sel = 0; in_data = '0; fault_inj = 0; out0_ready = 0; out1_ready = 0;
    rst_n = 1'b0;
    #12;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if ({out0_valid, out1_valid} !== 2'b00) begin errors++; $display("FAIL reset_valid got %b exp 00", {out0_valid, out1_valid}); end
    checks++; if ({out0_data, out1_data} !== 16'h0000) begin errors++; $display("FAIL reset_data got %h exp 0000", {out0_data, out1_data}); end
    checks++; if ({garbage_sel, cons_err, cnt0, cnt1} !== 10'd0) begin errors++; $display("FAIL reset_misc got %h exp 0", {garbage_sel, cons_err, cnt0, cnt1}); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_routing();
    out0_ready = 1; out1_ready = 1;
    drive(1, 0, 8'hA5);
    step();
    checks++; if ({out0_valid, out0_data} !== {1'b1, 8'hA5}) begin errors++; $display("FAIL basic_out0 got %b/%h exp 1/a5", out0_valid, out0_data); end
    checks++; if (garbage_sel !== 1'b0) begin errors++; $display("FAIL basic_garbage0 got %b exp 0", garbage_sel); end
    checks++; if (cnt0 !== 4'd1) begin errors++; $display("FAIL basic_cnt0 got %0d exp 1", cnt0); end
    drive(1, 1, 8'h3C);
    step();
    checks++; if ({out1_valid, out1_data} !== {1'b1, 8'h3C}) begin errors++; $display("FAIL basic_out1 got %b/%h exp 1/3c", out1_valid, out1_data); end
    checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL basic_out0_popped got %b exp 0", out0_valid); end
    checks++; if ({garbage_sel, cnt1} !== {1'b1, 4'd1}) begin errors++; $display("FAIL basic_garbage1_cnt1 got %b/%0d exp 1/1", garbage_sel, cnt1); end
    drive(0, 0, 8'h00);
    step();
    checks++; if ({cons_err, out1_valid} !== 2'b00) begin errors++; $display("FAIL basic_idle got %b exp 00", {cons_err, out1_valid}); end
  endtask

  task automatic test_lane_full();
    out0_ready = 0; out1_ready = 0;
    drive(1, 0, 8'h10); step();
    drive(1, 0, 8'h20); step();
    drive(1, 0, 8'h30);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
    out0_ready = 1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_no_passthru got %b exp 0", in_ready); end
    out0_ready = 0;
    step();
    checks++; if ({out0_data, cnt0} !== {8'h10, 4'd3}) begin errors++; $display("FAIL full_hold got %h/%0d exp 10/3", out0_data, cnt0); end
    drive(1, 1, 8'h11);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_other_lane_ready got %b exp 1", in_ready); end
    step();
    checks++; if ({out1_valid, out1_data} !== {1'b1, 8'h11}) begin errors++; $display("FAIL full_out1 got %b/%h exp 1/11", out1_valid, out1_data); end
    drive(0, 0, 8'h00);
    out0_ready = 1; out1_ready = 1;
    step();
    checks++; if ({out0_valid, out0_data, out1_valid} !== {1'b1, 8'h20, 1'b0}) begin errors++; $display("FAIL full_drain1 got %b/%h/%b exp 1/20/0", out0_valid, out0_data, out1_valid); end
    step();
    checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL full_drain2 got %b exp 0", out0_valid); end
  endtask

  task automatic test_back_to_back();
    out1_ready = 0;
    drive(1, 1, 8'h01); step();
    out1_ready = 1;
    drive(1, 1, 8'h02);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b exp 1", in_ready); end
    step();
    checks++; if ({out1_valid, out1_data} !== {1'b1, 8'h02}) begin errors++; $display("FAIL b2b_head got %b/%h exp 1/02", out1_valid, out1_data); end
    drive(0, 0, 8'h00);
    out1_ready = 0;
    step();
    checks++; if ({out1_valid, out1_data} !== {1'b1, 8'h02}) begin errors++; $display("FAIL b2b_hold got %b/%h exp 1/02", out1_valid, out1_data); end
    out1_ready = 1;
    step();
    checks++; if ({out1_valid, cnt1} !== {1'b0, 4'd4}) begin errors++; $display("FAIL b2b_occ1 got %b/%0d exp 0/4", out1_valid, cnt1); end
  endtask

  task automatic test_fault();
    out0_ready = 0;
    fault_inj = 1;
    drive(1, 0, 8'h01);
    step();
    fault_inj = 0;
    drive(0, 0, 8'h00);
    checks++; if (cons_err !== 1'b1) begin errors++; $display("FAIL fault_set got %b exp 1", cons_err); end
    checks++; if (out0_data !== 8'h00) begin errors++; $display("FAIL fault_data got %h exp 00", out0_data); end
    for (int i = 0; i < 10; i++) step();
    checks++; if (cons_err !== 1'b1) begin errors++; $display("FAIL fault_sticky got %b exp 1", cons_err); end
    do_reset();
    checks++; if (cons_err !== 1'b0) begin errors++; $display("FAIL fault_clear got %b exp 0", cons_err); end
  endtask

  task automatic test_counter_wrap();
    out0_ready = 1; out1_ready = 1;
    for (int i = 0; i < 17; i++) begin
      drive(1, 0, 8'(i));
      step();
    end
    drive(0, 0, 8'h00);
    checks++; if ({cnt0, cnt1} !== {4'd1, 4'd0}) begin errors++; $display("FAIL wrap_cnt got %0d/%0d exp 1/0", cnt0, cnt1); end
    checks++; if (cons_err !== 1'b0) begin errors++; $display("FAIL wrap_cons got %b exp 0", cons_err); end
    step();
  endtask

  task automatic test_async_reset();
    out0_ready = 0; out1_ready = 0;
    drive(1, 0, 8'hAA); step();
    drive(1, 0, 8'hBB); step();
    drive(1, 1, 8'hCC); step();
    drive(1, 1, 8'hDD); step();
    drive(0, 0, 8'h00);
    checks++; if ({out0_valid, out0_data, out1_valid, out1_data} !== {1'b1, 8'hAA, 1'b1, 8'hCC}) begin errors++; $display("FAIL arst_fill got %b/%h/%b/%h exp 1/aa/1/cc", out0_valid, out0_data, out1_valid, out1_data); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({out0_valid, out1_valid, out0_data, out1_data} !== 18'd0) begin errors++; $display("FAIL arst_outputs got %h exp 0", {out0_valid, out1_valid, out0_data, out1_data}); end
    checks++; if ({garbage_sel, cnt0, cnt1} !== 9'd0) begin errors++; $display("FAIL arst_misc got %h exp 0", {garbage_sel, cnt0, cnt1}); end
    rst_n = 1'b1;
    in_sel = 0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready got %b exp 1", in_ready); end
    step();
    checks++; if ({out0_valid, out1_valid} !== 2'b00) begin errors++; $display("FAIL arst_empty got %b exp 00", {out0_valid, out1_valid}); end
  endtask

  initial begin
    test_reset();
    test_basic_routing();
    test_lane_full();
    test_back_to_back();
    test_fault();
    test_counter_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fredkin_demux12_buf.md
Name: fredkin_demux12_buf

Overview:
- Registered 1:2 demultiplexer built from Fredkin (controlled-swap) cells. It is the inverse-direction companion of the Fredkin 2:1 MUX.
- Routes each accepted input word to lane 0 or lane 1 through a valid/ready handshake. Each lane has a 2-entry buffer.
- Checks the Fredkin conservation property (ones in == ones out) on every transfer and counts transfers per lane.
- Sits between a single reversible-logic data source and two downstream consumers.

Parameters:
- W, 8: data width in bits.
- CW, 16: width of each per-lane transfer counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept the input word this cycle.
- in_sel  in  1  lane select: 0 routes to lane 0, 1 routes to lane 1.
- in_data  in  W  input word.
- fault_inj  in  1  test hook: inverts bit 0 of the gate's lane-0 output before the conservation check and before the write.
- out0_valid  out  1  lane 0 head word valid.
- out0_ready  in  1  lane 0 consumer accepts the head word.
- out0_data  out  W  lane 0 head word.
- out1_valid  out  1  lane 1 head word valid.
- out1_ready  in  1  lane 1 consumer accepts the head word.
- out1_data  out  W  lane 1 head word.
- garbage_sel  out  1  registered control (P) output of the gate for the last accepted transfer.
- cons_err  out  1  sticky conservation-violation flag.
- cnt0  out  CW  accepted transfers routed to lane 0.
- cnt1  out  CW  accepted transfers routed to lane 1.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: in_ready=1, out*_valid=0, out*_data=0, garbage_sel=0, cons_err=0, cnt0=cnt1=0, both lane FIFOs empty.
- Assertion of rst_n mid-operation: immediately clears all state, including buffered words.
- Gate function: per bit i, F(c=in_sel, a=in_data[i], b=0) gives P=c, Q=~c&a (lane 0), R=c&a (lane 1). The unselected lane's gate output is all zeros.
- Handshake: in_ready = ~full[in_sel], a combinational function of in_sel. A transfer occurs when in_valid & in_ready at the rising edge.
- Transfer actions: write the selected gate output (Q or R) into that lane's FIFO, register garbage_sel=P, and increment the matching counter.
- Full lane with a same-cycle pop: in_ready stays 0. There is no pass-through.
- Latency: a word accepted at edge N appears as outN_valid/outN_data after edge N, if that lane was empty. Otherwise it appears behind the older entries.
- Ordering: strict per-lane FIFO order. There is no ordering guarantee across lanes.
- Lane FIFO: 2 entries per lane.
  - Pop when outN_valid & outN_ready.
  - Simultaneous push and pop on the same lane is legal. Occupancy is unchanged and data order is preserved.
  - The other lane is unaffected by stalls on one lane. There is no head-of-line blocking except through in_sel.
- outN_data: holds its value while outN_valid=1 and outN_ready=0. It must not change until the pop.
- Conservation check: on each transfer, popcount({P,Q,R}) is compared against popcount({c,a,b}).
  - On mismatch, cons_err goes to 1 after the edge and stays 1 until reset.
  - With fault_inj=0 a mismatch is impossible.
- Counters: wrap modulo 2^CW, with no saturation. At most one counter increments per cycle.
- in_valid=0: no state change except pops. in_sel and in_data are don't-care.

Decomposition:
- Package rl_pkg:
  - function fredkin(c,a,b) returning a 3-bit {P,Q,R};
  - localparam FIFO_DEPTH=2;
  - typedef lane_e {LANE0, LANE1}.
- Sub-module fredkin_gate_vec: W parallel Fredkin cells sharing one control, purely combinational, with outputs P, Q[W], R[W].
- Top level: contains the two lane FIFOs (inline registers plus 2-bit occupancy), the checker, and the counters.

Test Plan:
- Basic routing: after reset, send in_sel=0 data=8'hA5, then in_sel=1 data=8'h3C, both outN_ready=1 -> out0_data=A5 one cycle after accept, out1_data=3C; garbage_sel=0 then 1; cnt0=1, cnt1=1; cons_err=0.
- Lane full: hold out0_ready=0 and push 3 words to lane 0 -> first two accepted; in_ready=0 for the third. Meanwhile in_sel=1 word 8'h11 is still accepted, and out1_data=11.
- Simultaneous push and pop: lane 1 holds 1 entry (8'h01); in one cycle push 8'h02 with out1_ready=1 -> occupancy stays 1; head becomes 02 next cycle.
- Fault detection: fault_inj=1, in_sel=0, data=8'h01 -> cons_err=1 after the edge and still 1 after 10 idle cycles; only rst_n low clears it.
- Counter wrap: with CW=4, 17 transfers to lane 0 -> cnt0=1, cnt1=0.
- Async reset mid-stream: assert rst_n low between edges while both lanes hold 2 entries -> all outputs go to reset values immediately without a clock; after release, in_ready=1.
